// File: rtl/pet_pkg.sv
// Shared definitions for the pet stat engine: default sizes, channel names
// and a helper for pulling one stat out of the packed stat bus.
package pet_pkg;

  localparam int STAT_W_DEF  = 4;
  localparam int N_STATS_DEF = 6;

  typedef enum int unsigned {
    HUNGER    = 0,
    HAPPINESS = 1,
    HEALTH    = 2,
    HYGIENE   = 3,
    ENERGY    = 4,
    SOCIAL    = 5
  } stat_idx_e;

  function automatic logic [STAT_W_DEF-1:0] stat_slice(
    input logic [N_STATS_DEF*STAT_W_DEF-1:0] stats,
    input int unsigned                       idx
  );
    return STAT_W_DEF'(stats >> (idx * STAT_W_DEF));
  endfunction

endpackage

// File: rtl/pet_stat_cell.sv
// One stat channel: saturating counter with care rising-edge detection and a
// registered alert flag derived from the current stat value.
module pet_stat_cell
  import pet_pkg::*;
#(
  parameter int STAT_W      = STAT_W_DEF,
  parameter int DECAY_STEP  = 1,
  parameter int CARE_STEP   = 1,
  parameter int ALERT_LEVEL = 12,
  parameter int INIT_LEVEL  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              care_i,
  input  logic              decay_i,
  output logic [STAT_W-1:0] stat_o,
  output logic              alert_o
);

  localparam int SW = STAT_W + 2;
  localparam logic signed [SW-1:0] MAX_S  = SW'(2**STAT_W - 1);
  localparam logic signed [SW-1:0] DEC_S  = SW'(DECAY_STEP);
  localparam logic signed [SW-1:0] CARE_S = SW'(CARE_STEP);
  localparam logic [STAT_W-1:0]    INIT_V = STAT_W'(INIT_LEVEL);

  logic                 care_q;
  logic                 care_pulse;
  logic signed [SW-1:0] sum;
  logic [STAT_W-1:0]    stat_d;

  assign care_pulse = care_i & ~care_q;

  // Two guard bits keep the signed sum exact before clamping.
  always_comb begin
    sum = $signed({2'b00, stat_o});
    if (decay_i)    sum = sum + DEC_S;
    if (care_pulse) sum = sum - CARE_S;
    if (sum[SW-1])        stat_d = '0;
    else if (sum > MAX_S) stat_d = '1;
    else                  stat_d = sum[STAT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_o  <= INIT_V;
      care_q  <= 1'b0;
      alert_o <= 1'b0;
    end else begin
      stat_o  <= stat_d;
      care_q  <= care_i;
      alert_o <= (int'(stat_o) >= ALERT_LEVEL);
    end
  end

endmodule

// File: rtl/pet_stat_engine.sv
// N_STATS saturating pet stats: one random channel decays per game tick,
// care actions restore channels; alert/critical flags feed game-over logic.
module pet_stat_engine
  import pet_pkg::*;
#(
  parameter int N_STATS     = N_STATS_DEF,
  parameter int STAT_W      = STAT_W_DEF,
  parameter int TICK_DIV    = 27_000_000,
  parameter int DECAY_STEP  = 1,
  parameter int CARE_STEP   = 1,
  parameter int INIT_LEVEL  = 0,
  parameter int ALERT_LEVEL = 12,
  parameter int CRIT_COUNT  = 3,
  localparam int SEL_W      = $clog2(N_STATS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pause_i,
  input  logic [N_STATS-1:0]        care_i,
  input  logic [SEL_W-1:0]          rand_i,
  output logic [N_STATS*STAT_W-1:0] stats_o,
  output logic [N_STATS-1:0]        alert_o,
  output logic                      critical_o,
  output logic                      tick_o
);

  localparam int STAT_MAX = 2**STAT_W - 1;
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (DECAY_STEP > STAT_MAX || CARE_STEP > STAT_MAX || INIT_LEVEL > STAT_MAX) begin : g_chk_level
    $error("pet_stat_engine: step or init level exceeds STAT_MAX");
  end
  if (CRIT_COUNT > N_STATS || CRIT_COUNT == 0) begin : g_chk_crit
    $error("pet_stat_engine: CRIT_COUNT out of range");
  end
  if (TICK_DIV < 2) begin : g_chk_div
    $error("pet_stat_engine: TICK_DIV must be at least 2");
  end

  logic [CNT_W-1:0]   cnt;
  logic               tick_c;
  logic [N_STATS-1:0] decay;
  int                 n_alert;

  assign tick_c = ~pause_i & (cnt == CNT_LAST);

  for (genvar k = 0; k < N_STATS; k++) begin : g_cell
    // An out-of-range select matches no channel, so the tick decays nothing.
    assign decay[k] = tick_c & (rand_i == SEL_W'(k));

    pet_stat_cell #(
      .STAT_W      (STAT_W),
      .DECAY_STEP  (DECAY_STEP),
      .CARE_STEP   (CARE_STEP),
      .ALERT_LEVEL (ALERT_LEVEL),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .care_i  (care_i[k]),
      .decay_i (decay[k]),
      .stat_o  (stats_o[k*STAT_W +: STAT_W]),
      .alert_o (alert_o[k])
    );
  end

  always_comb begin
    n_alert = 0;
    for (int k = 0; k < N_STATS; k++) n_alert = n_alert + int'(alert_o[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      tick_o     <= 1'b0;
      critical_o <= 1'b0;
    end else begin
      tick_o     <= tick_c;
      critical_o <= (n_alert >= CRIT_COUNT);
      if (!pause_i) cnt <= tick_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pet_stat_engine.sv
// Self-checking bench for pet_stat_engine: directed vectors and corner
// sequences plus a randomized run against a cycle reference model.
module tb_pet_stat_engine;
  import pet_pkg::*;

  localparam int N    = 6;
  localparam int W    = 4;
  localparam int TD   = 4;
  localparam int INIT = 5;
  localparam int AL   = 12;
  localparam int CC   = 3;
  localparam int MAXV = 15;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           pause_i;
  logic [N-1:0]   care_i;
  logic [2:0]     rand_i;
  logic [N*W-1:0] stats_o;
  logic [N-1:0]   alert_o;
  logic           critical_o;
  logic           tick_o;

  always #5 clk = ~clk;

  pet_stat_engine #(
    .N_STATS(N), .STAT_W(W), .TICK_DIV(TD), .DECAY_STEP(1), .CARE_STEP(1),
    .INIT_LEVEL(INIT), .ALERT_LEVEL(AL), .CRIT_COUNT(CC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause_i(pause_i), .care_i(care_i),
    .rand_i(rand_i), .stats_o(stats_o), .alert_o(alert_o),
    .critical_o(critical_o), .tick_o(tick_o)
  );

  int n_pass;
  int n_total;

  // Reference model state
  int m_stat[N];
  bit m_care_q[N];
  bit m_alert[N];
  int m_cnt;
  bit m_crit;
  bit m_tick;

  typedef struct {
    logic [N-1:0]   care;
    logic [N*W-1:0] exp_stats;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [N*W-1:0] m_pack_stats();
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(m_stat[k]);
    return r;
  endfunction

  function automatic logic [N-1:0] m_pack_alert();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = m_alert[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_stat[k] = INIT; m_care_q[k] = 0; m_alert[k] = 0;
    end
    m_cnt = 0; m_crit = 0; m_tick = 0;
  endtask

  // One clock of the game rules, using the inputs present before the edge.
  task automatic model_clock();
    bit t;
    int na;
    int v;
    t  = !pause_i && (m_cnt == TD - 1);
    na = 0;
    for (int k = 0; k < N; k++) na += int'(m_alert[k]);
    m_crit = (na >= CC);
    for (int k = 0; k < N; k++) m_alert[k] = (m_stat[k] >= AL);
    for (int k = 0; k < N; k++) begin
      v = m_stat[k];
      if (t && int'(rand_i) == k) v += 1;
      if (care_i[k] && !m_care_q[k]) v -= 1;
      if (v < 0) v = 0;
      if (v > MAXV) v = MAXV;
      m_stat[k]   = v;
      m_care_q[k] = care_i[k];
    end
    m_tick = t;
    if (!pause_i) m_cnt = t ? 0 : m_cnt + 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("model stats", stats_o, m_pack_stats());
    check("model alert", alert_o, m_pack_alert());
    check("model critical", critical_o, m_crit);
    check("model tick", tick_o, m_tick);
  endtask

  task automatic apply_reset(input bit pause_val);
    rst_n = 1'b0; pause_i = pause_val; care_i = '0; rand_i = '0;
    model_reset();
    #1;
    check("reset stats", stats_o, 24'h555555);
    check("reset alert", alert_o, 0);
    check("reset critical", critical_o, 0);
    check("reset tick", tick_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_tick(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!tick_o && edges < 3 * TD);
    check("tick wait", tick_o, 1);
  endtask

  task automatic pulse_care(input int ch, input int times);
    for (int i = 0; i < times; i++) begin
      care_i[ch] = 1'b1; step();
      care_i[ch] = 1'b0; step();
    end
  endtask

  initial begin
    int e;
    n_pass = 0; n_total = 0;
    tbl[0] = '{care: 6'b000001, exp_stats: 24'h555554};
    tbl[1] = '{care: 6'b000001, exp_stats: 24'h555554};
    tbl[2] = '{care: 6'b000010, exp_stats: 24'h555544};
    tbl[3] = '{care: 6'b000011, exp_stats: 24'h555543};
    tbl[4] = '{care: 6'b111100, exp_stats: 24'h444443};
    tbl[5] = '{care: 6'b000000, exp_stats: 24'h444443};
    tbl[6] = '{care: 6'b111111, exp_stats: 24'h333332};
    tbl[7] = '{care: 6'b000000, exp_stats: 24'h333332};

    // Care-only vectors with the prescaler frozen
    apply_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      care_i = tbl[i].care;
      step();
      check($sformatf("tbl%0d stats", i), stats_o, tbl[i].exp_stats);
      check($sformatf("tbl%0d tick", i), tick_o, 0);
    end

    // First tick timing and decay saturation on channel 2
    apply_reset(1'b0);
    rand_i = 3'd2;
    wait_tick(e);
    check("first tick edges", e, 4);
    check("decay t1", stat_slice(stats_o, HEALTH), 6);
    for (int t = 2; t <= 20; t++) begin
      wait_tick(e);
      check($sformatf("decay t%0d", t), stat_slice(stats_o, HEALTH), (INIT + t > MAXV) ? MAXV : INIT + t);
      if (t == 7) begin
        check("alert2 not yet", alert_o[2], 0);
        step();
        check("alert2 rise", alert_o[2], 1);
      end
    end
    check("decay others", stats_o & ~24'h000F00, 24'h555055);

    // Care edges with out-of-range select so nothing decays
    rand_i = 3'd7;
    pulse_care(HUNGER, 2);
    check("care ch0 to 3", stat_slice(stats_o, HUNGER), 3);
    care_i[0] = 1'b1;
    repeat (10) step();
    check("care held once", stat_slice(stats_o, HUNGER), 2);
    care_i[0] = 1'b0;
    step();
    pulse_care(HUNGER, 5);
    check("care clamp 0", stat_slice(stats_o, HUNGER), 0);
    wait_tick(e);
    check("oor tick stats", stats_o, 24'h555F50);

    // Simultaneous decay and care at 0 and at STAT_MAX
    pulse_care(ENERGY, 5);
    check("ch4 to 0", stats_o, 24'h505F50);
    wait_tick(e);
    repeat (TD - 1) step();
    care_i[4] = 1'b1; rand_i = 3'd4;
    step();
    check("sim0 tick", tick_o, 1);
    check("sim0 ch4", stat_slice(stats_o, ENERGY), 0);
    care_i[4] = 1'b0;
    for (int t = 0; t < 16; t++) wait_tick(e);
    check("ch4 to 15", stat_slice(stats_o, ENERGY), 15);
    wait_tick(e);
    repeat (TD - 1) step();
    care_i[4] = 1'b1;
    step();
    check("sim15 tick", tick_o, 1);
    check("sim15 ch4", stat_slice(stats_o, ENERGY), 15);
    care_i[4] = 1'b0; rand_i = 3'd7;

    // Pause with prescaler at 2; care still applies
    wait_tick(e);
    repeat (2) step();
    pause_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      care_i[1] = (i == 3);
      step();
      check($sformatf("pause tick%0d", i), tick_o, 0);
    end
    check("pause care ch1", stat_slice(stats_o, HAPPINESS), 4);
    pause_i = 1'b0;
    wait_tick(e);
    check("resume tick edges", e, 2);

    // Critical: mid-run reset, then three channels to 12
    apply_reset(1'b0);
    for (int ch = 0; ch < 3; ch++) begin
      rand_i = 3'(ch);
      for (int t = 0; t < 7; t++) wait_tick(e);
    end
    rand_i = 3'd7;
    check("crit ch2 12", stat_slice(stats_o, HEALTH), 12);
    check("crit pre", critical_o, 0);
    step();
    check("crit third alert", alert_o, 6'b000111);
    check("crit lag", critical_o, 0);
    step();
    check("crit rise", critical_o, 1);
    care_i[1] = 1'b1;
    step();
    check("crit ch1 11", stat_slice(stats_o, HAPPINESS), 11);
    check("crit alert1 held", alert_o[1], 1);
    care_i[1] = 1'b0;
    step();
    check("crit alert1 drop", alert_o[1], 0);
    check("crit still", critical_o, 1);
    step();
    check("crit drop", critical_o, 0);

    // Randomized run against the model
    for (int i = 0; i < 800; i++) begin
      if (i == 400) apply_reset(1'b0);
      care_i  = N'($urandom_range(0, 63));
      rand_i  = 3'($urandom_range(0, 7));
      pause_i = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
